// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multiply/divide unit: op codes and FSM states.
package mips_pkg;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MFHI  = 3'd4;
  localparam logic [2:0] OP_MFLO  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } md_state_e;
endpackage

// File: rtl/mips_muldiv_step.sv
// One iteration of the shared mul/div datapath: shift-add (mode_div=0) or
// restoring subtract (mode_div=1) on a 2*WIDTH accumulator.
module mips_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 mode_div,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_out
);
  logic [WIDTH:0] sum, rem_sh, diff;
  logic           ge;

  always_comb begin
    // Multiply: low half holds the remaining multiplier bits, LSB first.
    sum    = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    // Divide: partial remainder shifted left by one, quotient bits enter at LSB.
    rem_sh = acc_in[2*WIDTH-1:WIDTH-1];
    ge     = rem_sh >= {1'b0, operand};
    diff   = rem_sh - {1'b0, operand};
    if (mode_div)
      acc_out = {(ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_in[WIDTH-2:0], ge};
    else
      acc_out = {sum, acc_in[WIDTH-1:1]};
  end
endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers; sign handling wraps an
// unsigned magnitude datapath, one bit per cycle.
module mips_muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] content1,
  input  logic [WIDTH-1:0] content2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  md_state_e state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_step, prod;
  logic [WIDTH-1:0]   opnd, raw_a, mag_a, mag_b, fin_hi, fin_lo;
  logic               neg_q, neg_r, zero_div, div_mode;
  logic               accept, is_mul_op, is_div_op, signed_op, last;

  assign accept    = start && !flush && (state == S_IDLE);
  assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign mag_a     = (signed_op && content1[WIDTH-1]) ? -content1 : content1;
  assign mag_b     = (signed_op && content2[WIDTH-1]) ? -content2 : content2;
  assign last      = (cnt == CNT_W'(WIDTH-1));
  assign busy      = (state != S_IDLE);

  mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode_div (state == S_DIV),
    .acc_in   (acc),
    .operand  (opnd),
    .acc_out  (acc_step)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && is_mul_op) state_nxt = S_MUL;
              else if (accept && is_div_op) state_nxt = S_DIV;
      S_MUL, S_DIV: if (flush) state_nxt = S_IDLE;
                    else if (last) state_nxt = S_FIN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // MIN_INT / -1 falls out naturally: magnitude quotient 2^(W-1) with neg_q=0.
  always_comb begin
    prod   = neg_q ? -acc : acc;
    fin_lo = zero_div ? {WIDTH{1'b1}} : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    fin_hi = zero_div ? raw_a : (neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      raw_a       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero_div    <= 1'b0;
      div_mode    <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (accept) begin
        div_by_zero <= 1'b0;
        cnt         <= '0;
        done        <= op[2];
        acc         <= is_div_op ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
        opnd        <= is_div_op ? mag_b : mag_a;
        raw_a       <= content1;
        neg_q       <= signed_op && (content1[WIDTH-1] ^ content2[WIDTH-1]);
        neg_r       <= signed_op && content1[WIDTH-1];
        zero_div    <= is_div_op && (content2 == '0);
        div_mode    <= is_div_op;
        case (op)
          OP_MFHI: result <= hi;
          OP_MFLO: result <= lo;
          OP_MTHI: hi     <= content1;
          OP_MTLO: lo     <= content1;
          default: ;
        endcase
      end
      if (state == S_MUL || state == S_DIV) begin
        acc <= acc_step;
        cnt <= cnt + CNT_W'(1);
      end
      if (state == S_FIN) begin
        done <= 1'b1;
        if (div_mode) begin
          hi          <= fin_hi;
          lo          <= fin_lo;
          div_by_zero <= zero_div;
        end else begin
          {hi, lo} <= prod;
        end
      end
    end
  end
endmodule
